// File: rtl/hl_match_checker_if.sv
// Bus between the H/L/IO byte-pair generator and its downstream match checker.
// The generator side drives the bytes and the word; the checker side drives results.
interface hl_match_checker_if #(
  parameter int CNT_W = 8
);
  logic [7:0]       H;
  logic [7:0]       L;
  logic [15:0]      IO;
  logic [15:0]      exp_word;
  logic             match;
  logic             mismatch;
  logic             timeout;
  logic [CNT_W-1:0] match_cnt;
  logic [CNT_W-1:0] err_cnt;
  logic [1:0]       state;

  modport master (
    output H, L, IO,
    input  exp_word, match, mismatch, timeout, match_cnt, err_cnt, state
  );

  modport slave (
    input  H, L, IO,
    output exp_word, match, mismatch, timeout, match_cnt, err_cnt, state
  );
endinterface

// File: rtl/hl_match_checker.sv
// Scoreboard stage of the match-test datapath: pairs an H byte and an L byte into
// an expected word, checks the IO word that follows, and tallies results.
module hl_match_checker #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 8
) (
  input logic              clk,
  input logic              rst,
  hl_match_checker_if.slave bus
);

  localparam int WCW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [WCW-1:0] LAST_WAIT = WCW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_L  = 2'd1,
    WAIT_IO = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [7:0]       hi_q, hi_d, lo_q, lo_d;
  logic [WCW-1:0]   wait_q, wait_d;
  logic [15:0]      exp_q;
  logic             match_q, mismatch_q, timeout_q;
  logic             match_d, mismatch_d, timeout_d;
  logic [CNT_W-1:0] match_cnt_q, err_cnt_q;

  logic h_ev, l_ev, io_ev;

  assign h_ev  = |bus.H;
  assign l_ev  = |bus.L;
  assign io_ev = |bus.IO;

  always_comb begin
    state_d    = state_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    wait_d     = wait_q;
    match_d    = 1'b0;
    mismatch_d = 1'b0;
    timeout_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (h_ev) begin
          hi_d   = bus.H;
          wait_d = '0;
          if (l_ev) begin
            lo_d    = bus.L;
            state_d = WAIT_IO;
          end else begin
            state_d = WAIT_L;
          end
        end else if (io_ev) begin
          mismatch_d = 1'b1;
        end
      end
      WAIT_L: begin
        if (io_ev) begin
          mismatch_d = 1'b1;
          state_d    = IDLE;
        end else if (l_ev) begin
          lo_d    = bus.L;
          wait_d  = '0;
          state_d = WAIT_IO;
        end else if (h_ev) begin
          // A fresh H while waiting for L is a resync, not an error.
          hi_d   = bus.H;
          wait_d = '0;
        end else if (wait_q == LAST_WAIT) begin
          timeout_d = 1'b1;
          state_d   = IDLE;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      WAIT_IO: begin
        if (io_ev) begin
          if (bus.IO == {hi_q, lo_q}) match_d = 1'b1;
          else                        mismatch_d = 1'b1;
          state_d = IDLE;
          // An H arriving with the IO word opens the next transaction at once.
          if (h_ev) begin
            hi_d   = bus.H;
            wait_d = '0;
            if (l_ev) begin
              lo_d    = bus.L;
              state_d = WAIT_IO;
            end else begin
              state_d = WAIT_L;
            end
          end
        end else if (wait_q == LAST_WAIT) begin
          timeout_d = 1'b1;
          state_d   = IDLE;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      hi_q        <= '0;
      lo_q        <= '0;
      wait_q      <= '0;
      exp_q       <= '0;
      match_q     <= 1'b0;
      mismatch_q  <= 1'b0;
      timeout_q   <= 1'b0;
      match_cnt_q <= '0;
      err_cnt_q   <= '0;
    end else begin
      state_q    <= state_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      wait_q     <= wait_d;
      exp_q      <= {hi_q, lo_q};
      match_q    <= match_d;
      mismatch_q <= mismatch_d;
      timeout_q  <= timeout_d;
      if (match_d && (match_cnt_q != '1))
        match_cnt_q <= match_cnt_q + 1'b1;
      if ((mismatch_d || timeout_d) && (err_cnt_q != '1))
        err_cnt_q <= err_cnt_q + 1'b1;
    end
  end

  assign bus.exp_word  = exp_q;
  assign bus.match     = match_q;
  assign bus.mismatch  = mismatch_q;
  assign bus.timeout   = timeout_q;
  assign bus.match_cnt = match_cnt_q;
  assign bus.err_cnt   = err_cnt_q;
  assign bus.state     = state_q;

endmodule
